// File: rtl/bb_pkg.sv
// Shared types and defaults for the Blackbone bus initiator.
package bb_pkg;

  // Default bus widths; bb_cmd_t is built from these.
  localparam int BB_AW = 8;
  localparam int BB_DW = 32;

  // Bus phase sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2
  } bb_mst_st_t;

  // One queued command.
  typedef struct packed {
    logic              we;
    logic [BB_AW-1:0]  addr;
    logic [BB_DW-1:0]  wdata;
  } bb_cmd_t;

  // Data driven onto per_dout for a command: reads put zero on the bus.
  function automatic logic [BB_DW-1:0] bus_wdata(input bb_cmd_t cmd);
    logic [BB_DW-1:0] res;
    if (cmd.we) begin
      res = cmd.wdata;
    end else begin
      res = {BB_DW{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/bb_cmd_fifo.sv
// In-order command buffer. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits are equal.
module bb_cmd_fifo
  import bb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  bb_cmd_t din,
  output bb_cmd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  bb_cmd_t      mem_r [DEPTH];
  logic [PW:0]  wr_ptr_r;
  logic [PW:0]  rd_ptr_r;
  logic         push_en_s;
  logic         pop_en_s;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_en_s = push && !full;
  assign pop_en_s  = pop && !empty;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                 (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign dout  = mem_r[rd_ptr_r[PW-1:0]];

  // Storage write; contents are don't-care while the slot is unused.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= din;
    end
  end

  // Read/write pointers; reset flushes the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bb_master.sv
// Blackbone bus initiator: queues commands and runs each as a
// setup/enable transfer, returning one response per command in order.
module bb_master
  import bb_pkg::*;
#(
  parameter int AW        = BB_AW,
  parameter int DW        = BB_DW,
  parameter int CMD_DEPTH = 4
) (
  input  logic          mclk,
  input  logic          mrst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic [AW-1:0] per_addr,
  output logic          per_we,
  output logic          per_en,
  output logic [DW-1:0] per_dout,
  input  logic [DW-1:0] per_din
);

  bb_mst_st_t    state_r;
  bb_mst_st_t    next_state_s;
  bb_cmd_t       fifo_din_s;
  bb_cmd_t       fifo_dout_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          pop_s;

  logic [AW-1:0] addr_nxt_s;
  logic          we_nxt_s;
  logic          en_nxt_s;
  logic [DW-1:0] dout_nxt_s;
  logic          rsp_valid_nxt_s;
  logic          rsp_we_nxt_s;
  logic [DW-1:0] rsp_rdata_nxt_s;

  assign fifo_din_s.we    = cmd_we;
  assign fifo_din_s.addr  = cmd_addr;
  assign fifo_din_s.wdata = cmd_wdata;

  assign cmd_ready = !fifo_full_s;
  assign busy      = !fifo_empty_s || (state_r != IDLE);

  bb_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (mclk),
    .rst   (mrst),
    .push  (cmd_valid),
    .pop   (pop_s),
    .din   (fifo_din_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state, bus and response values; a queued command is loaded
  // straight from ENABLE so the bus never idles between transfers.
  always_comb begin
    next_state_s    = state_r;
    pop_s           = 1'b0;
    addr_nxt_s      = per_addr;
    we_nxt_s        = per_we;
    en_nxt_s        = per_en;
    dout_nxt_s      = per_dout;
    rsp_valid_nxt_s = 1'b0;
    rsp_we_nxt_s    = rsp_we;
    rsp_rdata_nxt_s = rsp_rdata;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          addr_nxt_s   = fifo_dout_s.addr;
          we_nxt_s     = fifo_dout_s.we;
          dout_nxt_s   = bus_wdata(fifo_dout_s);
          en_nxt_s     = 1'b0;
          next_state_s = SETUP;
        end else begin
          en_nxt_s     = 1'b0;
          we_nxt_s     = 1'b0;
        end
      end
      SETUP: begin
        en_nxt_s     = 1'b1;
        next_state_s = ENABLE;
      end
      ENABLE: begin
        rsp_valid_nxt_s = 1'b1;
        rsp_we_nxt_s    = per_we;
        if (per_we) begin
          rsp_rdata_nxt_s = {DW{1'b0}};
        end else begin
          rsp_rdata_nxt_s = per_din;
        end
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          addr_nxt_s   = fifo_dout_s.addr;
          we_nxt_s     = fifo_dout_s.we;
          dout_nxt_s   = bus_wdata(fifo_dout_s);
          en_nxt_s     = 1'b0;
          next_state_s = SETUP;
        end else begin
          en_nxt_s     = 1'b0;
          we_nxt_s     = 1'b0;
          dout_nxt_s   = {DW{1'b0}};
          next_state_s = IDLE;
        end
      end
      default: begin
        en_nxt_s     = 1'b0;
        we_nxt_s     = 1'b0;
        next_state_s = IDLE;
      end
    endcase
  end

  // State, bus and response registers.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_r   <= IDLE;
      per_addr  <= {AW{1'b0}};
      per_we    <= 1'b0;
      per_en    <= 1'b0;
      per_dout  <= {DW{1'b0}};
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= {DW{1'b0}};
    end else begin
      state_r   <= next_state_s;
      per_addr  <= addr_nxt_s;
      per_we    <= we_nxt_s;
      per_en    <= en_nxt_s;
      per_dout  <= dout_nxt_s;
      rsp_valid <= rsp_valid_nxt_s;
      rsp_we    <= rsp_we_nxt_s;
      rsp_rdata <= rsp_rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_bb_master.sv
// Self-checking bench for bb_master with a simple responder and an
// in-order scoreboard of expected responses.
module tb_bb_master;

  logic        mclk = 1'b0;
  logic        mrst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [7:0]  per_addr;
  logic        per_we;
  logic        per_en;
  logic [31:0] per_dout;
  logic [31:0] per_din;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  logic [31:0] model_mem [256];
  logic [31:0] resp_mem [256];
  logic [31:0] rsp_data_log[$];
  int          rsp_cycle_log[$];
  int          rsp_count = 0;
  int          cycle = 0;
  bit          saw_not_ready = 1'b0;

  bb_master #(.AW(8), .DW(32), .CMD_DEPTH(4)) dut (
    .mclk      (mclk),
    .mrst      (mrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .per_addr  (per_addr),
    .per_we    (per_we),
    .per_en    (per_en),
    .per_dout  (per_dout),
    .per_din   (per_din)
  );

  always #5 mclk = ~mclk;

  // Cycle counter used to measure response spacing.
  always @(posedge mclk) cycle <= cycle + 1;

  // Responder: registers read data every cycle, commits writes at the end of enable.
  always @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      for (int i = 0; i < 256; i++) resp_mem[i] <= 32'(i);
      per_din <= 32'h0;
    end else begin
      per_din <= resp_mem[per_addr];
      if (per_en && per_we) resp_mem[per_addr] <= per_dout;
    end
  end

  // Scoreboard: compare each response against the oldest expectation.
  always @(negedge mclk) begin
    if (!mrst && rsp_valid) begin
      rsp_count++;
      rsp_data_log.push_back(rsp_rdata);
      rsp_cycle_log.push_back(cycle);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got we=%0b rdata=%h, expected no response", rsp_we, rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rsp_we !== e.we || rsp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rsp_order: got we=%0b rdata=%h, expected we=%0b rdata=%h",
                   rsp_we, rsp_rdata, e.we, e.rdata);
        end
      end
    end
  end

  task automatic reset_model();
    exp_q.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = 32'(i);
  endtask

  task automatic push_expected(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.we = we;
    if (we) begin
      model_mem[addr] = wdata;
      e.rdata = 32'h0;
    end else begin
      e.rdata = model_mem[addr];
    end
    exp_q.push_back(e);
  endtask

  // Offers one command and returns #1 after the edge that accepted it.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      @(negedge mclk);
      if (cmd_ready) begin
        push_expected(we, addr, wdata);
        @(posedge mclk);
        #1;
        ok = 1'b1;
        break;
      end else begin
        saw_not_ready = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rsp_count >= target) break;
      @(posedge mclk);
    end
    #1;
    if (rsp_count < target) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", rsp_count, target);
    end
  endtask

  task automatic test_single_write();
    issue(1'b1, 8'h10, 32'hDEADBEEF);
    cmd_valid = 1'b0;
    @(posedge mclk); #1;
    checks++;
    if (per_we !== 1'b1 || per_en !== 1'b0 || per_addr !== 8'h10 || per_dout !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_setup: got we=%0b en=%0b addr=%h dout=%h, expected 1 0 10 deadbeef",
               per_we, per_en, per_addr, per_dout);
    end
    @(posedge mclk); #1;
    checks++;
    if (per_en !== 1'b1 || per_we !== 1'b1) begin
      errors++;
      $display("FAIL wr_enable: got en=%0b we=%0b, expected 1 1", per_en, per_we);
    end
    @(posedge mclk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_rsp: got valid=%0b we=%0b rdata=%h, expected 1 1 0", rsp_valid, rsp_we, rsp_rdata);
    end
    checks++;
    if (resp_mem[8'h10] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_commit: got mem[10]=%h, expected deadbeef", resp_mem[8'h10]);
    end
    @(posedge mclk); #1;
    checks++;
    if (busy !== 1'b0 || per_en !== 1'b0 || per_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle: got busy=%0b en=%0b we=%0b, expected 0 0 0", busy, per_en, per_we);
    end
  endtask

  task automatic test_reset();
    @(posedge mclk); #3;
    mrst = 1'b1;
    reset_model();
    #1;
    checks++;
    if (per_en !== 1'b0 || per_we !== 1'b0 || per_addr !== 8'h00 || per_dout !== 32'h0 ||
        rsp_valid !== 1'b0 || rsp_we !== 1'b0 || rsp_rdata !== 32'h0 ||
        cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: got en=%0b we=%0b addr=%h dout=%h rv=%0b rwe=%0b rd=%h rdy=%0b busy=%0b, expected all 0 except rdy=1",
               per_en, per_we, per_addr, per_dout, rsp_valid, rsp_we, rsp_rdata, cmd_ready, busy);
    end
    @(posedge mclk); @(posedge mclk); #1;
    mrst = 1'b0;
  endtask

  task automatic test_read();
    issue(1'b0, 8'h05, 32'hFFFF_FFFF);
    cmd_valid = 1'b0;
    @(posedge mclk); #1;
    checks++;
    if (per_we !== 1'b0 || per_dout !== 32'h0 || per_addr !== 8'h05) begin
      errors++;
      $display("FAIL rd_setup: got we=%0b dout=%h addr=%h, expected 0 0 05", per_we, per_dout, per_addr);
    end
    @(posedge mclk); @(posedge mclk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 32'h5) begin
      errors++;
      $display("FAIL rd_rsp: got valid=%0b we=%0b rdata=%h, expected 1 0 00000005", rsp_valid, rsp_we, rsp_rdata);
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_back_to_back();
    int base;
    base = rsp_count;
    issue(1'b1, 8'h20, 32'h1234);
    issue(1'b0, 8'h20, 32'h0);
    issue(1'b0, 8'h21, 32'h0);
    cmd_valid = 1'b0;
    wait_rsp(base + 3, 30);
    checks++;
    if (rsp_cycle_log[base+1] - rsp_cycle_log[base] !== 2 ||
        rsp_cycle_log[base+2] - rsp_cycle_log[base+1] !== 2) begin
      errors++;
      $display("FAIL b2b_spacing: got gaps %0d %0d, expected 2 2",
               rsp_cycle_log[base+1] - rsp_cycle_log[base], rsp_cycle_log[base+2] - rsp_cycle_log[base+1]);
    end
    checks++;
    if (rsp_data_log[base+1] !== 32'h1234 || rsp_data_log[base+2] !== 32'h21) begin
      errors++;
      $display("FAIL b2b_data: got %h %h, expected 00001234 00000021", rsp_data_log[base+1], rsp_data_log[base+2]);
    end
  endtask

  task automatic test_full();
    int base;
    base = rsp_count;
    saw_not_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      issue((k < 4) ? 1'b1 : 1'b0, 8'h40 + 8'(k % 4), 32'hA500_0000 + 32'(k));
    end
    cmd_valid = 1'b0;
    checks++;
    if (saw_not_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready: got cmd_ready never low, expected it to drop when full");
    end
    wait_rsp(base + 8, 60);
    repeat (4) @(posedge mclk);
    #1;
    checks++;
    if (rsp_count - base !== 8 || exp_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_count: got %0d rsps, %0d pending, busy=%0b, expected 8 0 0",
               rsp_count - base, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int  base;
    bit  hit;
    base = rsp_count;
    hit  = 1'b0;
    issue(1'b0, 8'h01, 32'h0);
    issue(1'b0, 8'h02, 32'h0);
    issue(1'b0, 8'h03, 32'h0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      if (per_en) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_enable: got per_en never high, expected an enable phase");
    end
    mrst = 1'b1;
    reset_model();
    #1;
    checks++;
    if (per_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got en=%0b rv=%0b busy=%0b rdy=%0b, expected 0 0 0 1",
               per_en, rsp_valid, busy, cmd_ready);
    end
    @(posedge mclk); @(posedge mclk); #1;
    mrst = 1'b0;
    repeat (8) @(posedge mclk);
    #1;
    checks++;
    if (rsp_count !== base || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush: got %0d rsps busy=%0b, expected 0 rsps busy=0", rsp_count - base, busy);
    end
    issue(1'b0, 8'h07, 32'h0);
    cmd_valid = 1'b0;
    wait_rsp(base + 1, 20);
    checks++;
    if (rsp_data_log[base] !== 32'h7) begin
      errors++;
      $display("FAIL mid_recover: got rdata=%h, expected 00000007", rsp_data_log[base]);
    end
  endtask

  initial begin
    reset_model();
    repeat (2) @(posedge mclk);
    #1;
    mrst = 1'b0;
    test_single_write();
    test_reset();
    test_read();
    test_back_to_back();
    test_full();
    test_reset_mid();
    repeat (3) @(posedge mclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
